// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings, FSM states, iteration ops.
// ALU_MUL is only executed when ALU_MUL_EN is defined; otherwise it decodes as unknown.
package alu_multicycle_pkg;

  localparam int unsigned FUNC_W = 5;

  localparam logic [FUNC_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [FUNC_W-1:0] ALU_SUB    = 5'd1;
  localparam logic [FUNC_W-1:0] ALU_AND    = 5'd2;
  localparam logic [FUNC_W-1:0] ALU_OR     = 5'd3;
  localparam logic [FUNC_W-1:0] ALU_XOR    = 5'd4;
  localparam logic [FUNC_W-1:0] ALU_LUI    = 5'd5;
  localparam logic [FUNC_W-1:0] ALU_LOAD   = 5'd6;
  localparam logic [FUNC_W-1:0] ALU_STORE  = 5'd7;
  localparam logic [FUNC_W-1:0] ALU_ADDI   = 5'd8;
  localparam logic [FUNC_W-1:0] ALU_BRANCH = 5'd9;
  localparam logic [FUNC_W-1:0] ALU_JUMP   = 5'd10;
  localparam logic [FUNC_W-1:0] ALU_BEQ    = 5'd11;
  localparam logic [FUNC_W-1:0] ALU_BNE    = 5'd12;
  localparam logic [FUNC_W-1:0] ALU_BGE    = 5'd13;
  localparam logic [FUNC_W-1:0] ALU_BLT    = 5'd14;
  localparam logic [FUNC_W-1:0] ALU_SLL    = 5'd15;
  localparam logic [FUNC_W-1:0] ALU_SRL    = 5'd16;
  localparam logic [FUNC_W-1:0] ALU_SRA    = 5'd17;
  localparam logic [FUNC_W-1:0] ALU_MUL    = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ITER_SLL = 2'd0,
    ITER_SRL = 2'd1,
    ITER_SRA = 2'd2,
    ITER_MUL = 2'd3
  } iter_op_e;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between register-read, the multi-cycle ALU and writeback.
interface alu_multicycle_if
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [FUNC_W-1:0] func;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [WIDTH-1:0]  imm;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              branch_taken;
  logic              busy;

  modport master (
    output flush, in_valid, func, a, b, imm, out_ready,
    input  in_ready, out_valid, result, branch_taken, busy
  );

  modport slave (
    input  flush, in_valid, func, a, b, imm, out_ready,
    output in_ready, out_valid, result, branch_taken, busy
  );

endinterface

// File: rtl/alu_multicycle_iter_unit.sv
// Iterative datapath: one shift bit per step, or one shift-add multiplier bit per step.
// Multiplier registers exist only when ALU_MUL_EN is defined.
module alu_iter_unit
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW  = $clog2(WIDTH),
  localparam int unsigned CW   = SHW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  iter_op_e         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CW-1:0]    count,
  output logic             done_c,
  output logic [WIDTH-1:0] result_c
);

  iter_op_e         op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
`else
  logic unused_b;
  assign unused_b = ^b;
`endif

  // Value of the accumulator after the current step
  always_comb begin
    acc_d = acc_q;
    case (op_q)
      ITER_SLL: acc_d = acc_q << 1;
      ITER_SRL: acc_d = acc_q >> 1;
      ITER_SRA: acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      ITER_MUL: begin
`ifdef ALU_MUL_EN
        acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`else
        acc_d = acc_q;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= ITER_SLL;
      acc_q    <= '0;
      cnt_q    <= '0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else if (start) begin
      op_q     <= op;
      acc_q    <= (op == ITER_MUL) ? '0 : a;
      cnt_q    <= count;
`ifdef ALU_MUL_EN
      mcand_q  <= a;
      mplier_q <= b;
`endif
    end else if (step && (cnt_q != '0)) begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_q - CW'(1);
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
`endif
    end
  end

  // Final step happens in the cycle the counter sits at one
  assign done_c   = step && (cnt_q == CW'(1));
  assign result_c = acc_d;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle ops resolve on accept,
// shifts (and MUL when ALU_MUL_EN is defined) iterate in alu_iter_unit.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          BR_SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  alu_multicycle_if.slave  bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  state_e           state_q, state_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic             lt_c;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_result;
  logic             sc_taken;
  logic             is_iter;
  iter_op_e         iter_op_c;
  logic [CW-1:0]    iter_cnt_c;
  logic             start_c;
  logic             iter_done_c;
  logic [WIDTH-1:0] iter_result_c;

  assign accept = bus.in_valid && in_ready_q && !bus.flush;
  assign shamt  = bus.b[SHW-1:0];
  assign lt_c   = BR_SIGNED ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);

  // Decode: single-cycle results and iteration setup
  always_comb begin
    sc_result  = '0;
    sc_taken   = 1'b0;
    is_iter    = 1'b0;
    iter_op_c  = ITER_SLL;
    iter_cnt_c = CW'(shamt);
    case (bus.func)
      ALU_ADD, ALU_LOAD:   sc_result = bus.a + bus.b;
      ALU_ADDI, ALU_STORE: sc_result = bus.a + bus.imm;
      ALU_SUB:             sc_result = bus.a - bus.b;
      ALU_AND:             sc_result = bus.a & bus.b;
      ALU_OR:              sc_result = bus.a | bus.b;
      ALU_XOR:             sc_result = bus.a ^ bus.b;
      ALU_LUI:             sc_result = bus.imm;
      ALU_BRANCH, ALU_JUMP: sc_taken = 1'b1;
      ALU_BEQ:             sc_taken = (bus.a == bus.b);
      ALU_BNE:             sc_taken = (bus.a != bus.b);
      ALU_BGE:             sc_taken = !lt_c;
      ALU_BLT:             sc_taken = lt_c;
      ALU_SLL: begin
        iter_op_c = ITER_SLL;
        is_iter   = (shamt != '0);
        sc_result = bus.a;
      end
      ALU_SRL: begin
        iter_op_c = ITER_SRL;
        is_iter   = (shamt != '0);
        sc_result = bus.a;
      end
      ALU_SRA: begin
        iter_op_c = ITER_SRA;
        is_iter   = (shamt != '0);
        sc_result = bus.a;
      end
`ifdef ALU_MUL_EN
      ALU_MUL: begin
        iter_op_c  = ITER_MUL;
        iter_cnt_c = CW'(WIDTH);
        is_iter    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Next state and next output values; flush overrides everything
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    taken_d  = taken_q;
    start_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          start_c = is_iter;
          if (is_iter) begin
            state_d = ST_EXEC;
          end else begin
            state_d  = ST_DONE;
            result_d = sc_result;
            taken_d  = sc_taken;
          end
        end
      end
      ST_EXEC: begin
        if (iter_done_c) begin
          state_d  = ST_DONE;
          result_d = iter_result_c;
          taken_d  = 1'b0;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      taken_d  = taken_q;
      start_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d == ST_EXEC);
      result_q    <= result_d;
      taken_q     <= taken_d;
    end
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .step     (state_q == ST_EXEC),
    .op       (iter_op_c),
    .a        (bus.a),
    .b        (bus.b),
    .count    (iter_cnt_c),
    .done_c   (iter_done_c),
    .result_c (iter_result_c)
  );

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.branch_taken = taken_q;

endmodule
